// File: rtl/spi_slave_byte_pkg.sv
// Shared constants for the SPI mode-0 byte responder.
package spi_slave_pkg;

    // Default word size, synchroniser depth and fill word
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam logic [7:0]  IDLE_FILL_DEF   = 8'hFF;

    // FSM encoding
    localparam int unsigned ST_W      = 1;
    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_ACTIVE = 1'b1;

endpackage : spi_slave_pkg

// File: rtl/spi_slave_byte_pin_sync.sv
// N-stage synchroniser for one asynchronous pad plus rise/fall detection
// on the synchronised value. Reset loads the pad's idle level into every
// stage so no spurious edge is reported when reset releases.
module spi_pin_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic pin_s,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Next value of the shift chain and the edge-detect history flop
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_i};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and history registers, synchronous reset to idle level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pin_s  = sync_q[STAGES-1];
    assign rise_c =  pin_s & ~prev_q;
    assign fall_c = ~pin_s &  prev_q;

endmodule : spi_pin_sync

// File: rtl/spi_slave_byte.sv
// SPI mode-0 responder. Pins are oversampled in the clk_50 domain; words
// move between the link and fabric through a one-entry TX holding register
// (valid/ready) and an RX strobe. Multi-word frames run while SS_n is low.
module spi_slave_byte
    import spi_slave_pkg::*;
#(
    parameter int unsigned          DATA_W      = DATA_W_DEF,
    parameter int unsigned          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [DATA_W-1:0]    IDLE_FILL   = DATA_W'(IDLE_FILL_DEF)
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned SH_W  = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronised pins and edge strobes
    logic sclk_s, sclk_rise_c, sclk_fall_c;
    logic mosi_s, mosi_rise_c, mosi_fall_c;
    logic ss_s,   ss_rise_c,   ss_fall_c;

    spi_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk    (clk_50),
        .reset  (reset),
        .pin_i  (spi_sclk),
        .pin_s  (sclk_s),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk    (clk_50),
        .reset  (reset),
        .pin_i  (spi_mosi),
        .pin_s  (mosi_s),
        .rise_c (mosi_rise_c),
        .fall_c (mosi_fall_c)
    );

    spi_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_ss (
        .clk    (clk_50),
        .reset  (reset),
        .pin_i  (spi_ss_n),
        .pin_s  (ss_s),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    // Only the edges of SCLK/SS_n and the level of MOSI are consumed
    logic unused_sync_c;
    assign unused_sync_c = ^{sclk_s, mosi_rise_c, mosi_fall_c, ss_s};

    // State registers
    logic [ST_W-1:0]   state_q,       state_d;
    logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [SH_W-1:0]   rx_shift_q,    rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q,    tx_shift_d;
    logic [DATA_W-1:0] hold_q,        hold_d;
    logic              tx_ready_q,    tx_ready_d;
    logic              reload_pend_q, reload_pend_d;
    logic [DATA_W-1:0] rx_data_q,     rx_data_d;
    logic              rx_valid_q,    rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_abort_q, frame_abort_d;
    logic              busy_q,        busy_d;
    logic              miso_oe_q,     miso_oe_d;

    // Request to load the TX shifter this cycle, and whether fabric data
    // skips the holding register on its way to the shifter
    logic load_c;
    logic bypass_c;

    // Next-state logic: frame FSM, bit counter, shifters, holding register
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        reload_pend_d = reload_pend_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        busy_d        = busy_q;
        miso_oe_d     = miso_oe_q;
        load_c        = 1'b0;
        bypass_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // SCLK activity is ignored until the master selects us
                if (ss_fall_c) begin
                    state_d       = ST_ACTIVE;
                    bit_cnt_d     = '0;
                    reload_pend_d = 1'b0;
                    busy_d        = 1'b1;
                    miso_oe_d     = 1'b1;
                    load_c        = 1'b1;
                end
            end

            ST_ACTIVE: begin
                // Deselect takes priority over any coincident SCLK edge
                if (ss_rise_c) begin
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    miso_oe_d     = 1'b0;
                    reload_pend_d = 1'b0;
                    bit_cnt_d     = '0;
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                end else if (sclk_rise_c) begin
                    rx_shift_d = {rx_shift_q[SH_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d     = '0;
                        rx_data_d     = {rx_shift_q, mosi_s};
                        rx_valid_d    = 1'b1;
                        reload_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    // Word boundary: next word replaces the shifter instead of shifting
                    if (reload_pend_q) begin
                        load_c        = 1'b1;
                        reload_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shifter load: holding register first, then live fabric data, else fill
        if (load_c) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else if (tx_valid) begin
                tx_shift_d = tx_data;
                bypass_c   = 1'b1;
            end else begin
                tx_shift_d    = IDLE_FILL;
                tx_underrun_d = 1'b1;
            end
        end

        // Fabric handshake into the holding register
        if (tx_valid && tx_ready_q && !bypass_c) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    // Register update with synchronous active-high reset
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            reload_pend_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            busy_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            reload_pend_q <= reload_pend_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            busy_q        <= busy_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    assign spi_miso    = tx_shift_q[DATA_W-1];
    assign spi_miso_oe = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = busy_q;

endmodule : spi_slave_byte

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte acting as an SPI mode-0 master.
module tb_spi_slave_byte;

    localparam int HALF = 6;   // clk_50 cycles per SCLK half period

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       spi_sclk, spi_mosi, spi_ss_n;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, frame_abort, busy;

    spi_slave_byte dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #10 clk_50 = ~clk_50;

    int n_chk  = 0;
    int n_fail = 0;

    // Strobe monitor: cumulative pulse counts and log of received words
    int         rx_cnt = 0;
    int         un_cnt = 0;
    int         ab_cnt = 0;
    logic [7:0] rx_log [64];

    always @(negedge clk_50) begin
        if (rx_valid) begin
            if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_underrun) un_cnt = un_cnt + 1;
        if (frame_abort) ab_cnt = ab_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic preload(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        chk("preload_ready_before", 32'(tx_ready), 32'd1);
        wait_clk(1);
        tx_valid = 1'b0;
        chk("preload_ready_after", 32'(tx_ready), 32'd0);
    endtask

    // One word, MSB first; the final falling SCLK coincides with SS_n rising
    task automatic xfer(input logic [7:0] mo, input bit last, input bit wr,
                        input logic [7:0] wv, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo[i];
            if (wr && i == 4) begin
                tx_data  = wv;
                tx_valid = 1'b1;
                wait_clk(1);
                tx_valid = 1'b0;
                wait_clk(HALF - 1);
            end else begin
                wait_clk(HALF);
            end
            mi[i]    = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
            if (last && i == 0) spi_ss_n = 1'b1;
        end
    endtask

    typedef struct {
        bit         pre_en;
        logic [7:0] pre;
        int         nw;
        logic [7:0] mosi0;
        logic [7:0] mosi1;
        bit         wr_mid;
        logic [7:0] wr_val;
        logic [7:0] miso0;
        logic [7:0] miso1;
        int         exp_un;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m0, m1;
        int         rx0, un0, ab0;
        bit         idle_bad;

        vecs[0] = '{1'b1, 8'hA5, 1, 8'h3C, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h00, 0};
        vecs[1] = '{1'b0, 8'h00, 2, 8'h01, 8'h02, 1'b0, 8'h00, 8'hFF, 8'hFF, 2};
        vecs[2] = '{1'b1, 8'h11, 2, 8'h5A, 8'hC7, 1'b1, 8'h22, 8'h11, 8'h22, 0};
        vecs[3] = '{1'b1, 8'h5A, 1, 8'hE1, 8'h00, 1'b0, 8'h00, 8'h5A, 8'h00, 0};

        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_ss_n = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);

        // Reset values
        chk("rst_oe",       32'(spi_miso_oe), 32'd0);
        chk("rst_miso",     32'(spi_miso),    32'd0);
        chk("rst_ready",    32'(tx_ready),    32'd1);
        chk("rst_rx_data",  32'(rx_data),     32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_strobes",  32'({rx_valid, tx_underrun, frame_abort}), 32'd0);

        // SCLK/MOSI toggling with SS_n high must be ignored
        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = i[1];
            wait_clk(1);
            if (spi_miso_oe || busy || !tx_ready) idle_bad = 1'b1;
        end
        spi_sclk = 1'b0;
        wait_clk(HALF);
        chk("idle_outputs", 32'(idle_bad), 32'd0);
        chk("idle_strobes", 32'(rx_cnt + un_cnt + ab_cnt), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            rx0 = rx_cnt;
            un0 = un_cnt;
            ab0 = ab_cnt;
            if (vecs[v].pre_en) preload(vecs[v].pre);
            spi_ss_n = 1'b0;
            wait_clk(HALF);
            chk($sformatf("v%0d_busy_on", v),  32'(busy),        32'd1);
            chk($sformatf("v%0d_oe_on", v),    32'(spi_miso_oe), 32'd1);
            chk($sformatf("v%0d_ready", v),    32'(tx_ready),    32'd1);
            xfer(vecs[v].mosi0, vecs[v].nw == 1, vecs[v].wr_mid, vecs[v].wr_val, m0);
            chk($sformatf("v%0d_miso0", v), 32'(m0), 32'(vecs[v].miso0));
            if (vecs[v].nw == 2) begin
                xfer(vecs[v].mosi1, 1'b1, 1'b0, 8'h00, m1);
                chk($sformatf("v%0d_miso1", v), 32'(m1), 32'(vecs[v].miso1));
            end
            wait_clk(HALF);
            chk($sformatf("v%0d_busy_off", v), 32'(busy),            32'd0);
            chk($sformatf("v%0d_oe_off", v),   32'(spi_miso_oe),     32'd0);
            chk($sformatf("v%0d_underrun", v), 32'(un_cnt - un0),    32'(vecs[v].exp_un));
            chk($sformatf("v%0d_rx_cnt", v),   32'(rx_cnt - rx0),    32'(vecs[v].nw));
            chk($sformatf("v%0d_abort", v),    32'(ab_cnt - ab0),    32'd0);
            chk($sformatf("v%0d_rx0", v),      32'(rx_log[rx0]),     32'(vecs[v].mosi0));
            if (vecs[v].nw == 2) begin
                chk($sformatf("v%0d_rx1", v),  32'(rx_log[rx0 + 1]), 32'(vecs[v].mosi1));
                chk($sformatf("v%0d_rx_hold", v), 32'(rx_data),      32'(vecs[v].mosi1));
            end else begin
                chk($sformatf("v%0d_rx_hold", v), 32'(rx_data),      32'(vecs[v].mosi0));
            end
        end

        // Partial word: SS_n rises after 5 SCLK rises
        rx0 = rx_cnt;
        ab0 = ab_cnt;
        spi_ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = i[0];
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(HALF);
        chk("abort_pulse", 32'(ab_cnt - ab0), 32'd1);
        chk("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("abort_busy",  32'(busy),         32'd0);
        spi_ss_n = 1'b0;
        wait_clk(HALF);
        xfer(8'h96, 1'b1, 1'b0, 8'h00, m0);
        wait_clk(HALF);
        chk("post_abort_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        chk("post_abort_rx",     32'(rx_log[rx0]),  32'h96);
        chk("post_abort_abort",  32'(ab_cnt - ab0), 32'd1);

        // Reset mid-word, then a fresh frame
        spi_ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        reset    = 1'b1;
        spi_ss_n = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(HALF);
        chk("midrst_rx_data", 32'(rx_data),     32'd0);
        chk("midrst_busy",    32'(busy),        32'd0);
        chk("midrst_oe",      32'(spi_miso_oe), 32'd0);
        chk("midrst_ready",   32'(tx_ready),    32'd1);
        rx0 = rx_cnt;
        ab0 = ab_cnt;
        spi_ss_n = 1'b0;
        wait_clk(HALF);
        xfer(8'hC3, 1'b1, 1'b0, 8'h00, m0);
        wait_clk(HALF);
        chk("midrst_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        chk("midrst_rx",     32'(rx_data),      32'hC3);
        chk("midrst_abort",  32'(ab_cnt - ab0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_spi_slave_byte
